// File: rtl/qci_meter_bw_lookup_p.sv
// Qci per-stream reserved-bandwidth lookup stage.
// Looks up a runtime-programmable bandwidth table by meter ID on the first
// beat of each frame. A 3-stage register pipeline delays the AXI-Stream beat
// and its per-frame sidebands so the result lines up with the frame on tx.
module qci_meter_bw_lookup_p #(
   parameter int unsigned     DATA_W      = 64,
   parameter int unsigned     ID_W        = 12,
   parameter int unsigned     TABLE_DEPTH = 128,
   parameter int unsigned     BW_W        = 32,
   parameter int unsigned     LEN_W       = 11,
   parameter logic [BW_W-1:0] DEFAULT_BW  = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   rx_axis_tdata,
   input  logic [DATA_W/8-1:0] rx_axis_tkeep,
   input  logic                rx_axis_tlast,
   input  logic                rx_axis_tvalid,
   output logic                rx_axis_tready,
   output logic [DATA_W-1:0]   tx_axis_tdata,
   output logic [DATA_W/8-1:0] tx_axis_tkeep,
   output logic                tx_axis_tlast,
   output logic                tx_axis_tvalid,
   input  logic                tx_axis_tready,
   input  logic [LEN_W-1:0]    frame_len_in,
   input  logic [ID_W-1:0]     meter_id_in,
   input  logic [ID_W-1:0]     gate_id_in,
   input  logic [LEN_W-1:0]    max_frame_len_in,
   output logic [LEN_W-1:0]    frame_len_out,
   output logic [ID_W-1:0]     meter_id_out,
   output logic [ID_W-1:0]     gate_id_out,
   output logic [LEN_W-1:0]    max_frame_len_out,
   output logic [BW_W-1:0]     reserved_bandwidth_out,
   output logic                meter_miss_out,
   input  logic                cfg_wr_en,
   input  logic                cfg_rd_en,
   input  logic [ID_W-1:0]     cfg_addr,
   input  logic [BW_W-1:0]     cfg_wdata,
   output logic [BW_W-1:0]     cfg_rdata,
   output logic                cfg_rd_valid
);

   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned IDX_W  = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
   localparam int unsigned IDP1_W = ID_W + 1;
   localparam logic [ID_W:0] DEPTH_LIM = IDP1_W'(TABLE_DEPTH);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_INFRAME = 1'b1
   } sof_state_t;

   sof_state_t state_q, state_d;

   logic en, accept, sof;
   logic lookup_hit, cfg_wr_hit, cfg_rd_hit;
   logic [IDX_W-1:0] lookup_idx, cfg_idx;

   logic [BW_W-1:0] bw_mem [TABLE_DEPTH];
   logic [BW_W-1:0] ram_rd_q;

   logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic              s1_sof_q, s1_sof_d, s1_hit_q, s1_hit_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [KEEP_W-1:0] s1_keep_q, s1_keep_d;
   logic [LEN_W-1:0]  s1_flen_q, s1_flen_d, s1_mlen_q, s1_mlen_d;
   logic [ID_W-1:0]   s1_meter_q, s1_meter_d, s1_gate_q, s1_gate_d;

   logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic              s2_miss_q, s2_miss_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic [KEEP_W-1:0] s2_keep_q, s2_keep_d;
   logic [LEN_W-1:0]  s2_flen_q, s2_flen_d, s2_mlen_q, s2_mlen_d;
   logic [ID_W-1:0]   s2_meter_q, s2_meter_d, s2_gate_q, s2_gate_d;
   logic [BW_W-1:0]   s2_bw_q, s2_bw_d;

   logic              s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
   logic              s3_miss_q, s3_miss_d;
   logic [DATA_W-1:0] s3_data_q, s3_data_d;
   logic [KEEP_W-1:0] s3_keep_q, s3_keep_d;
   logic [LEN_W-1:0]  s3_flen_q, s3_flen_d, s3_mlen_q, s3_mlen_d;
   logic [ID_W-1:0]   s3_meter_q, s3_meter_d, s3_gate_q, s3_gate_d;
   logic [BW_W-1:0]   s3_bw_q, s3_bw_d;

   logic [BW_W-1:0] cfg_rdata_q, cfg_rdata_d;
   logic            cfg_rd_valid_q, cfg_rd_valid_d;

   assign en             = !s3_valid_q || tx_axis_tready;
   assign accept         = rx_axis_tvalid && en;
   assign sof            = accept && (state_q == ST_IDLE);
   assign lookup_idx     = meter_id_in[IDX_W-1:0];
   assign cfg_idx        = cfg_addr[IDX_W-1:0];
   assign lookup_hit     = {1'b0, meter_id_in} < DEPTH_LIM;
   assign cfg_wr_hit     = {1'b0, cfg_addr} < DEPTH_LIM;
   assign cfg_rd_hit     = cfg_wr_hit;

   // Bandwidth table: config writes plus the read-first lookup read, which
   // advances with the pipeline so a stalled lookup result is never lost.
   always_ff @(posedge clk) begin
      if (cfg_wr_en && cfg_wr_hit) begin
         bw_mem[cfg_idx] <= cfg_wdata;
      end
      if (en) begin
         ram_rd_q <= bw_mem[lookup_idx];
      end
   end

   // SOF tracker: any beat accepted while idle starts a frame; tlast ends it.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = rx_axis_tlast ? ST_IDLE : ST_INFRAME;
      end
   end

   // Config readback samples the table before this cycle's write lands.
   always_comb begin
      cfg_rdata_d    = cfg_rdata_q;
      cfg_rd_valid_d = cfg_rd_en;
      if (cfg_rd_en) begin
         cfg_rdata_d = cfg_rd_hit ? bw_mem[cfg_idx] : DEFAULT_BW;
      end
   end

   // Pipeline next state: everything holds unless the global advance is set;
   // sidebands and bandwidth only reload on SOF, so later beats inherit them.
   always_comb begin
      s1_valid_d = s1_valid_q;  s1_last_d  = s1_last_q;   s1_sof_d  = s1_sof_q;
      s1_hit_d   = s1_hit_q;    s1_data_d  = s1_data_q;   s1_keep_d = s1_keep_q;
      s1_flen_d  = s1_flen_q;   s1_mlen_d  = s1_mlen_q;
      s1_meter_d = s1_meter_q;  s1_gate_d  = s1_gate_q;
      s2_valid_d = s2_valid_q;  s2_last_d  = s2_last_q;   s2_miss_d = s2_miss_q;
      s2_data_d  = s2_data_q;   s2_keep_d  = s2_keep_q;   s2_bw_d   = s2_bw_q;
      s2_flen_d  = s2_flen_q;   s2_mlen_d  = s2_mlen_q;
      s2_meter_d = s2_meter_q;  s2_gate_d  = s2_gate_q;
      s3_valid_d = s3_valid_q;  s3_last_d  = s3_last_q;   s3_miss_d = s3_miss_q;
      s3_data_d  = s3_data_q;   s3_keep_d  = s3_keep_q;   s3_bw_d   = s3_bw_q;
      s3_flen_d  = s3_flen_q;   s3_mlen_d  = s3_mlen_q;
      s3_meter_d = s3_meter_q;  s3_gate_d  = s3_gate_q;
      if (en) begin
         s1_valid_d = accept;
         s1_last_d  = rx_axis_tlast;
         s1_data_d  = rx_axis_tdata;
         s1_keep_d  = rx_axis_tkeep;
         s1_sof_d   = sof;
         if (sof) begin
            s1_hit_d   = lookup_hit;
            s1_flen_d  = frame_len_in;
            s1_mlen_d  = max_frame_len_in;
            s1_meter_d = meter_id_in;
            s1_gate_d  = gate_id_in;
         end
         s2_valid_d = s1_valid_q;  s2_last_d  = s1_last_q;
         s2_data_d  = s1_data_q;   s2_keep_d  = s1_keep_q;
         s2_flen_d  = s1_flen_q;   s2_mlen_d  = s1_mlen_q;
         s2_meter_d = s1_meter_q;  s2_gate_d  = s1_gate_q;
         if (s1_valid_q && s1_sof_q) begin
            s2_bw_d   = s1_hit_q ? ram_rd_q : DEFAULT_BW;
            s2_miss_d = !s1_hit_q;
         end
         s3_valid_d = s2_valid_q;  s3_last_d  = s2_last_q;   s3_miss_d = s2_miss_q;
         s3_data_d  = s2_data_q;   s3_keep_d  = s2_keep_q;   s3_bw_d   = s2_bw_q;
         s3_flen_d  = s2_flen_q;   s3_mlen_d  = s2_mlen_q;
         s3_meter_d = s2_meter_q;  s3_gate_d  = s2_gate_q;
      end
   end

   // State registers with synchronous active-low reset; the table is not reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         s1_valid_q <= 1'b0; s1_last_q <= 1'b0; s1_sof_q <= 1'b0; s1_hit_q <= 1'b0;
         s1_data_q  <= '0;   s1_keep_q <= '0;   s1_flen_q <= '0;  s1_mlen_q <= '0;
         s1_meter_q <= '0;   s1_gate_q <= '0;
         s2_valid_q <= 1'b0; s2_last_q <= 1'b0; s2_miss_q <= 1'b0; s2_bw_q <= '0;
         s2_data_q  <= '0;   s2_keep_q <= '0;   s2_flen_q <= '0;   s2_mlen_q <= '0;
         s2_meter_q <= '0;   s2_gate_q <= '0;
         s3_valid_q <= 1'b0; s3_last_q <= 1'b0; s3_miss_q <= 1'b0; s3_bw_q <= '0;
         s3_data_q  <= '0;   s3_keep_q <= '0;   s3_flen_q <= '0;   s3_mlen_q <= '0;
         s3_meter_q <= '0;   s3_gate_q <= '0;
         cfg_rdata_q    <= '0;
         cfg_rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d; s1_last_q <= s1_last_d; s1_sof_q <= s1_sof_d;
         s1_hit_q   <= s1_hit_d;   s1_data_q <= s1_data_d; s1_keep_q <= s1_keep_d;
         s1_flen_q  <= s1_flen_d;  s1_mlen_q <= s1_mlen_d;
         s1_meter_q <= s1_meter_d; s1_gate_q <= s1_gate_d;
         s2_valid_q <= s2_valid_d; s2_last_q <= s2_last_d; s2_miss_q <= s2_miss_d;
         s2_bw_q    <= s2_bw_d;    s2_data_q <= s2_data_d; s2_keep_q <= s2_keep_d;
         s2_flen_q  <= s2_flen_d;  s2_mlen_q <= s2_mlen_d;
         s2_meter_q <= s2_meter_d; s2_gate_q <= s2_gate_d;
         s3_valid_q <= s3_valid_d; s3_last_q <= s3_last_d; s3_miss_q <= s3_miss_d;
         s3_bw_q    <= s3_bw_d;    s3_data_q <= s3_data_d; s3_keep_q <= s3_keep_d;
         s3_flen_q  <= s3_flen_d;  s3_mlen_q <= s3_mlen_d;
         s3_meter_q <= s3_meter_d; s3_gate_q <= s3_gate_d;
         cfg_rdata_q    <= cfg_rdata_d;
         cfg_rd_valid_q <= cfg_rd_valid_d;
      end
   end

   assign rx_axis_tready         = en;
   assign tx_axis_tvalid         = s3_valid_q;
   assign tx_axis_tdata          = s3_data_q;
   assign tx_axis_tkeep          = s3_keep_q;
   assign tx_axis_tlast          = s3_last_q;
   assign frame_len_out          = s3_flen_q;
   assign meter_id_out           = s3_meter_q;
   assign gate_id_out            = s3_gate_q;
   assign max_frame_len_out      = s3_mlen_q;
   assign reserved_bandwidth_out = s3_bw_q;
   assign meter_miss_out         = s3_miss_q;
   assign cfg_rdata              = cfg_rdata_q;
   assign cfg_rd_valid           = cfg_rd_valid_q;

endmodule

// File: tb/tb_qci_meter_bw_lookup_p.sv
// Scoreboard bench for qci_meter_bw_lookup_p: a driver pushes hand-computed
// expected tx beats on rx acceptance; a monitor compares whatever tx presents.
module tb_qci_meter_bw_lookup_p;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ID_W   = 12;
   localparam int unsigned DEPTH  = 128;
   localparam int unsigned BW_W   = 32;
   localparam int unsigned LEN_W  = 11;
   localparam logic [31:0] DEF_BW = 32'h0000_FFFF;

   logic              clk, rst;
   logic [63:0]       rx_axis_tdata, tx_axis_tdata;
   logic [7:0]        rx_axis_tkeep, tx_axis_tkeep;
   logic              rx_axis_tlast, rx_axis_tvalid, rx_axis_tready;
   logic              tx_axis_tlast, tx_axis_tvalid, tx_axis_tready;
   logic [10:0]       frame_len_in, max_frame_len_in, frame_len_out, max_frame_len_out;
   logic [11:0]       meter_id_in, gate_id_in, meter_id_out, gate_id_out;
   logic [31:0]       reserved_bandwidth_out, cfg_wdata, cfg_rdata;
   logic              meter_miss_out, cfg_wr_en, cfg_rd_en, cfg_rd_valid;
   logic [11:0]       cfg_addr;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [31:0] bw;
      logic        miss;
      logic [11:0] meter;
      logic [11:0] gate;
      logic [10:0] flen;
      logic [10:0] mlen;
      int          acc;
      bit          chk_lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   tag = 32'h100;
   bit   rand_ready = 1'b0;

   qci_meter_bw_lookup_p #(
      .DATA_W(DATA_W), .ID_W(ID_W), .TABLE_DEPTH(DEPTH),
      .BW_W(BW_W), .LEN_W(LEN_W), .DEFAULT_BW(DEF_BW)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
      .rx_axis_tlast(rx_axis_tlast), .rx_axis_tvalid(rx_axis_tvalid),
      .rx_axis_tready(rx_axis_tready),
      .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
      .tx_axis_tlast(tx_axis_tlast), .tx_axis_tvalid(tx_axis_tvalid),
      .tx_axis_tready(tx_axis_tready),
      .frame_len_in(frame_len_in), .meter_id_in(meter_id_in),
      .gate_id_in(gate_id_in), .max_frame_len_in(max_frame_len_in),
      .frame_len_out(frame_len_out), .meter_id_out(meter_id_out),
      .gate_id_out(gate_id_out), .max_frame_len_out(max_frame_len_out),
      .reserved_bandwidth_out(reserved_bandwidth_out), .meter_miss_out(meter_miss_out),
      .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Egress ready: always ready, or a coin toss per cycle during the stall test.
   initial begin
      tx_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: any presented beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (tx_axis_tvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", tx_axis_tdata);
         end else begin
            mon_e = exp_q[0];
            checkOutput("tdata", tx_axis_tdata, mon_e.data);
            checkOutput("tkeep", 64'(tx_axis_tkeep), 64'(mon_e.keep));
            checkOutput("tlast", 64'(tx_axis_tlast), 64'(mon_e.last));
            checkOutput("bandwidth", 64'(reserved_bandwidth_out), 64'(mon_e.bw));
            checkOutput("meter_miss", 64'(meter_miss_out), 64'(mon_e.miss));
            checkOutput("meter_id", 64'(meter_id_out), 64'(mon_e.meter));
            checkOutput("gate_id", 64'(gate_id_out), 64'(mon_e.gate));
            checkOutput("frame_len", 64'(frame_len_out), 64'(mon_e.flen));
            checkOutput("max_frame_len", 64'(max_frame_len_out), 64'(mon_e.mlen));
            if (tx_axis_tready) begin
               if (mon_e.chk_lat) checkOutput("latency", 64'(cyc - mon_e.acc), 64'd3);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Drives one beat (caller is just after a rising edge) and holds it until
   // accepted; cfg write strobes set by the caller last exactly one edge.
   task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep,
                                input logic last, input logic [11:0] meter,
                                input logic [11:0] gate, input logic [10:0] flen,
                                input logic [10:0] mlen, input bit push, input exp_t e);
      int  guard = 0;
      bit  done  = 1'b0;
      rx_axis_tdata    = data;
      rx_axis_tkeep    = keep;
      rx_axis_tlast    = last;
      meter_id_in      = meter;
      gate_id_in       = gate;
      frame_len_in     = flen;
      max_frame_len_in = mlen;
      rx_axis_tvalid   = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (rx_axis_tready) begin
            done  = 1'b1;
            e.acc = cyc;
            if (push) exp_q.push_back(e);
         end
         @(posedge clk);
         #1;
         cfg_wr_en = 1'b0;
         guard++;
         if (!done && guard > 1000) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_accept_timeout: got no acceptance, expected within 1000 cycles");
            done = 1'b1;
         end
      end
      rx_axis_tvalid = 1'b0;
   endtask

   // Frame sender: real sidebands only on SOF, scrambled ones on later beats.
   task automatic sendFrame(input int n, input logic [11:0] meter, input logic [11:0] gate,
                            input logic [10:0] flen, input logic [10:0] mlen,
                            input logic [31:0] exp_bw, input logic exp_miss,
                            input bit chk_lat, input bit gaps, input bit wr,
                            input logic [11:0] wr_addr, input logic [31:0] wr_data);
      exp_t e;
      for (int b = 0; b < n; b++) begin
         if (gaps && (b % 3 == 1)) begin
            repeat (2) begin @(posedge clk); #1; end
         end
         e.data    = {32'(tag), 32'(b)};
         e.last    = (b == n - 1);
         e.keep    = e.last ? 8'h0F : 8'hFF;
         e.bw      = exp_bw;
         e.miss    = exp_miss;
         e.meter   = meter;
         e.gate    = gate;
         e.flen    = flen;
         e.mlen    = mlen;
         e.acc     = 0;
         e.chk_lat = chk_lat;
         if (b == 0 && wr) begin
            cfg_addr  = wr_addr;
            cfg_wdata = wr_data;
            cfg_wr_en = 1'b1;
         end
         if (b == 0)
            applyStimulus(e.data, e.keep, e.last, meter, gate, flen, mlen, 1'b1, e);
         else
            applyStimulus(e.data, e.keep, e.last, ~meter, ~gate, ~flen, ~mlen, 1'b1, e);
      end
      tag++;
   endtask

   task automatic cfgWrite(input logic [11:0] addr, input logic [31:0] data);
      cfg_addr  = addr;
      cfg_wdata = data;
      cfg_wr_en = 1'b1;
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b0;
   endtask

   task automatic cfgRead(input string name, input logic [11:0] addr, input logic [31:0] exp_val,
                          input bit also_wr, input logic [31:0] wdata);
      cfg_addr  = addr;
      cfg_wdata = wdata;
      cfg_rd_en = 1'b1;
      cfg_wr_en = also_wr;
      @(posedge clk);
      #1;
      cfg_rd_en = 1'b0;
      cfg_wr_en = 1'b0;
      checkOutput({name, "_rd_valid"}, 64'(cfg_rd_valid), 64'd1);
      checkOutput({name, "_rdata"}, 64'(cfg_rdata), 64'(exp_val));
      @(posedge clk);
      #1;
      checkOutput({name, "_rd_valid_pulse"}, 64'(cfg_rd_valid), 64'd0);
   endtask

   task automatic waitDrain();
      int g = 0;
      while (exp_q.size() != 0 && g < 2000) begin
         @(posedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, "_tvalid"}, 64'(tx_axis_tvalid), 64'd0);
      checkOutput({name, "_tdata"}, tx_axis_tdata, 64'd0);
      checkOutput({name, "_tkeep_tlast"}, 64'({tx_axis_tkeep, tx_axis_tlast}), 64'd0);
      checkOutput({name, "_bw"}, 64'(reserved_bandwidth_out), 64'd0);
      checkOutput({name, "_miss"}, 64'(meter_miss_out), 64'd0);
      checkOutput({name, "_ids"}, 64'({meter_id_out, gate_id_out}), 64'd0);
      checkOutput({name, "_lens"}, 64'({frame_len_out, max_frame_len_out}), 64'd0);
      checkOutput({name, "_cfg"}, 64'({cfg_rdata, cfg_rd_valid}), 64'd0);
   endtask

   initial begin
      exp_t dummy;
      dummy = '{default: '0};
      rst = 1'b0;
      rx_axis_tdata = '0; rx_axis_tkeep = '0; rx_axis_tlast = 1'b0; rx_axis_tvalid = 1'b0;
      frame_len_in = '0; max_frame_len_in = '0; meter_id_in = '0; gate_id_in = '0;
      cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] table programming and config port");
      cfgWrite(12'd5, 32'd1000);
      cfgWrite(12'd7, 32'd2500);
      cfgWrite(12'd72, 32'd4242);
      cfgWrite(12'd127, 32'd31337);
      cfgWrite(12'd200, 32'd123);
      cfgRead("oor_write_ignored", 12'd72, 32'd4242, 1'b0, 32'd0);
      cfgRead("oor_read", 12'd200, DEF_BW, 1'b0, 32'd0);
      cfgRead("read_top_entry", 12'd127, 32'd31337, 1'b0, 32'd0);
      cfgRead("rd_wr_same_cycle", 12'd72, 32'd4242, 1'b1, 32'd5151);
      cfgRead("rd_after_wr", 12'd72, 32'd5151, 1'b0, 32'd0);

      $display("[TB] single 4-beat frame, meter 5");
      sendFrame(4, 12'd5, 12'd9, 11'd64, 11'd1500, 32'd1000, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      waitDrain();

      $display("[TB] back-to-back frames incl. single-beat and boundary IDs");
      sendFrame(4, 12'd5, 12'd3, 11'd100, 11'd1522, 32'd1000, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      sendFrame(1, 12'd7, 12'd4, 11'd60, 11'd1522, 32'd2500, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      sendFrame(1, 12'd127, 12'd6, 11'd70, 11'd1000, 32'd31337, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      sendFrame(2, 12'd128, 12'd1, 11'd80, 11'd1000, DEF_BW, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      waitDrain();

      $display("[TB] out-of-range meter 200");
      sendFrame(3, 12'd200, 12'd2, 11'd90, 11'd1500, DEF_BW, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      waitDrain();

      $display("[TB] random backpressure with rx gaps");
      rand_ready = 1'b1;
      sendFrame(20, 12'd7, 12'd11, 11'd1200, 11'd1500, 32'd2500, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 32'd0);
      waitDrain();
      rand_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] write/lookup collision on meter 5");
      sendFrame(2, 12'd5, 12'd12, 11'd128, 11'd1500, 32'd1000, 1'b0, 1'b1, 1'b0, 1'b1, 12'd5, 32'd7777);
      sendFrame(2, 12'd5, 12'd13, 11'd129, 11'd1500, 32'd7777, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      waitDrain();
      cfgRead("rd_after_collision", 12'd5, 32'd7777, 1'b0, 32'd0);

      $display("[TB] reset in the middle of a 6-beat frame");
      applyStimulus(64'hDEAD_0000, 8'hFF, 1'b0, 12'd7, 12'd8, 11'd300, 11'd1500, 1'b0, dummy);
      applyStimulus(64'hDEAD_0001, 8'hFF, 1'b0, 12'd0, 12'd0, 11'd0, 11'd0, 1'b0, dummy);
      rx_axis_tdata  = 64'hDEAD_0002;
      rx_axis_tvalid = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rx_axis_tvalid = 1'b0;
      checkResetState("mid_frame_reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
      sendFrame(3, 12'd7, 12'd5, 11'd200, 11'd1500, 32'd2500, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0);
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
